// File: rtl/spi_slave_rx_pkg.sv
// Shared SPI definitions: default word width, synchronizer depth, receiver FSM
// state encodings and the SPI mode-0 clock polarity/phase constants.
package spi_slave_rx_pkg;

    localparam int SPI_DATA_WIDTH  = 8;
    localparam int SPI_SYNC_STAGES = 2;

    // Mode 0: SCLK idles low, data sampled on the rising edge, changed on the falling edge.
    localparam bit SPI_CPOL = 1'b0;
    localparam bit SPI_CPHA = 1'b0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/spi_slave_rx_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with single-cycle rise and
// fall pulses taken from the last sync stage against one extra history flop.
module spi_slave_rx_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] pipe;
    logic              last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe <= {STAGES{RESET_VAL}};
            last <= RESET_VAL;
        end else begin
            pipe <= {pipe[STAGES-2:0], din};
            last <= pipe[STAGES-1];
        end
    end

    assign sync = pipe[STAGES-1];
    assign rise = sync & ~last;
    assign fall = ~sync & last;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 target receiver: oversampled SCLK/MOSI/SS, MSB-first words on rx_data.
// Optional transmit path (tx_byte in, MISO out) is built when SPI_SLAVE_MISO_EN is defined.
module spi_slave_rx
    import spi_slave_rx_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  SCLK,
    input  logic                  MOSI,
    input  logic                  SS,
`ifdef SPI_SLAVE_MISO_EN
    input  logic [DATA_WIDTH-1:0] tx_byte,
    output logic                  MISO,
`endif
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  busy,
    output logic                  state_dbg
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);

    state_t                state, state_next;
    logic [CW-1:0]         bit_cnt, cnt_next;
    logic [DATA_WIDTH-1:0] shift, shift_next;
    logic                  word_done, err_next;

    logic sclk_s, sclk_rise, sclk_fall;
    logic ss_s, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_pipe;
    logic                   mosi_s;

    spi_slave_rx_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk   (clk),
        .reset (reset),
        .din   (SCLK),
        .sync  (sclk_s),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_slave_rx_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
        .clk   (clk),
        .reset (reset),
        .din   (SS),
        .sync  (ss_s),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    // Same depth as the SCLK synchronizer so MOSI is stable when the rise pulse fires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mosi_pipe <= '0;
        end else begin
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], MOSI};
        end
    end
    assign mosi_s = mosi_pipe[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A full count is retired the cycle after it is reached, even if SS rose meanwhile,
    // so a word whose last bit coincides with SS rising still completes cleanly.
    always_comb begin
        state_next = state;
        cnt_next   = bit_cnt;
        shift_next = shift;
        word_done  = (bit_cnt == FULL);
        err_next   = 1'b0;
        if (word_done) begin
            cnt_next = '0;
        end
        case (state)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_next = ST_SHIFT;
                    cnt_next   = '0;
                    shift_next = '0;
                end
            end
            ST_SHIFT: begin
                if (sclk_rise) begin
                    shift_next = {shift[DATA_WIDTH-2:0], mosi_s};
                    cnt_next   = cnt_next + CW'(1);
                end
                if (ss_rise) begin
                    state_next = ST_IDLE;
                    if (cnt_next != '0 && cnt_next != FULL) begin
                        err_next = 1'b1;
                        cnt_next = '0;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // rx_valid is a strobe with no back-pressure: a consumer must take rx_data in the
    // cycle rx_valid is high; rx_data then holds until the next completed word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            bit_cnt   <= cnt_next;
            shift     <= shift_next;
            rx_valid  <= word_done;
            frame_err <= err_next;
            if (word_done) begin
                rx_data <= shift;
            end
        end
    end

    assign busy      = ~ss_s;
    assign state_dbg = (state == ST_SHIFT);

`ifdef SPI_SLAVE_MISO_EN
    logic [DATA_WIDTH-1:0] tx_shift;

    // The falling edge right after a word's last rise sees bit_cnt==0 and must not
    // advance, otherwise the freshly reloaded MSB would be lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_shift <= '0;
        end else if ((ss_fall && state == ST_IDLE) || word_done) begin
            tx_shift <= tx_byte;
        end else if (sclk_fall && state == ST_SHIFT && bit_cnt != '0) begin
            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
        end
    end

    assign MISO = busy & tx_shift[DATA_WIDTH-1];
`else
    logic unused_sclk;
    assign unused_sclk = sclk_fall | sclk_s;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: emulates an SPI mode-0 master (25 clk per half bit) and
// checks received words, frame errors and latency against a word-level reference model.
module tb_spi_slave_rx;

    localparam int W    = 8;
    localparam int HALF = 25;
    localparam int LAT  = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         SCLK;
    logic         MOSI;
    logic         SS;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         frame_err;
    logic         busy;
    logic         state_dbg;
`ifdef SPI_SLAVE_MISO_EN
    logic [W-1:0] tx_byte;
    logic         MISO;
    logic [W-1:0] miso_cap;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int err_pulses = 0;
    int exp_err = 0;
    int both_cnt = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int lat_q[$];

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    spi_slave_rx dut (
        .clk       (clk),
        .reset     (reset),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .SS        (SS),
`ifdef SPI_SLAVE_MISO_EN
        .tx_byte   (tx_byte),
        .MISO      (MISO),
`endif
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // monitor: collect DUT events just after each active edge
    always @(posedge clk) begin
        #1;
        if (rx_valid) begin
            got_q.push_back(rx_data);
            lat_q.push_back(cyc - last_rise_cyc);
        end
        if (frame_err) err_pulses++;
        if (rx_valid && frame_err) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_half();
        repeat (HALF) @(negedge clk);
    endtask

    // driver + reference model: a frame of n bits yields n/8 whole words, and a
    // frame error whenever n is not a multiple of the word size
    task automatic send_bits(input logic [63:0] bits, input int n, input bit early_ss);
        SS   = 1'b0;
        MOSI = 1'b0;
        wait_half();
        chk("busy_in_frame", {31'd0, busy}, 32'd1);
        for (int i = 0; i < n; i++) begin
            MOSI = bits[n-1-i];
            wait_half();
`ifdef SPI_SLAVE_MISO_EN
            miso_cap = {miso_cap[W-2:0], MISO};
`endif
            SCLK = 1'b1;
            last_rise_cyc = cyc;
            if (early_ss && i == n - 1) SS = 1'b1;
            wait_half();
            SCLK = 1'b0;
        end
        wait_half();
        SS = 1'b1;
        repeat (10) @(negedge clk);
        for (int w = 0; w < n / W; w++) begin
            exp_q.push_back(bits[n-1-W*w -: W]);
        end
        if (n % W != 0) exp_err++;
    endtask

    // scoreboard
    task automatic check_sb(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            chk({tag, "_data"}, {24'd0, got_q.pop_front()}, {24'd0, exp_q.pop_front()});
        end
        chk({tag, "_frame_err"}, err_pulses, exp_err);
        chk({tag, "_valid_and_err"}, both_cnt, 0);
        if (lat_q.size() > 0) chk({tag, "_latency"}, lat_q[$], LAT);
        got_q.delete();
        exp_q.delete();
        lat_q.delete();
    endtask

    initial begin
        logic [63:0] rnd;
        int          n;

        reset = 1'b1;
        SCLK  = 1'b0;
        MOSI  = 1'b0;
        SS    = 1'b1;
`ifdef SPI_SLAVE_MISO_EN
        tx_byte  = '0;
        miso_cap = '0;
`endif
        repeat (5) @(negedge clk);
        chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
        chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_state", {31'd0, state_dbg}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // single word
        send_bits(64'hA5, 8, 1'b0);
        check_sb("single_a5");
        chk("hold_a5", {24'd0, rx_data}, 32'hA5);

        // two words in one SS frame
        send_bits(64'h3CFF, 16, 1'b0);
        check_sb("two_words");

        // short frame then a good word
        rnd = 64'($urandom_range(0, 31));
        send_bits(rnd, 5, 1'b0);
        send_bits(64'h81, 8, 1'b0);
        check_sb("short_then_81");
        chk("hold_81", {24'd0, rx_data}, 32'h81);

        // SCLK/MOSI activity with SS high is ignored
        SS = 1'b1;
        for (int i = 0; i < 16; i++) begin
            MOSI = 1'($urandom_range(0, 1));
            SCLK = 1'b1;
            repeat (5) @(negedge clk);
            SCLK = 1'b0;
            repeat (5) @(negedge clk);
        end
        chk("ss_high_busy", {31'd0, busy}, 32'd0);
        chk("ss_high_state", {31'd0, state_dbg}, 32'd0);
        check_sb("ss_high_toggle");

        // reset in the middle of a word
        SS = 1'b0;
        wait_half();
        for (int i = 0; i < 4; i++) begin
            MOSI = 1'b1;
            wait_half();
            SCLK = 1'b1;
            wait_half();
            SCLK = 1'b0;
        end
        chk("mid_word_state", {31'd0, state_dbg}, 32'd1);
        reset = 1'b1;
        SS    = 1'b1;
        MOSI  = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_reset_rx_data", {24'd0, rx_data}, 32'd0);
        chk("mid_reset_busy", {31'd0, busy}, 32'd0);
        chk("mid_reset_state", {31'd0, state_dbg}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        send_bits(64'h5A, 8, 1'b0);
        check_sb("after_reset_5a");

        // SS rises in the same cycle as the last bit's SCLK rise
        send_bits(64'h96, 8, 1'b1);
        check_sb("ss_coincident");

        // random frames of random length
        for (int k = 0; k < 6; k++) begin
            n   = $urandom_range(1, 24);
            rnd = {$urandom, $urandom};
            send_bits(rnd, n, 1'b0);
            check_sb("random_frame");
        end

`ifdef SPI_SLAVE_MISO_EN
        tx_byte = 8'hC3;
        send_bits(64'h00, 8, 1'b0);
        chk("miso_bits", {24'd0, miso_cap}, 32'hC3);
        check_sb("miso_frame");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
